// File: rtl/mix_columns_stream.sv
// mix_columns_stream: byte-stream AES MixColumns engine.
// Loads a 16-byte state, mixes one column per cycle, streams it out.
module mix_columns_stream #(
    parameter int BEAT_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*BEAT_BYTES-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int NBEATS = 16 / BEAT_BYTES;
    localparam int BW = 8 * BEAT_BYTES;
    localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    generate
        if (!(BEAT_BYTES == 1 || BEAT_BYTES == 2 || BEAT_BYTES == 4 ||
              BEAT_BYTES == 8 || BEAT_BYTES == 16)) begin : g_bad_beat
            $error("mix_columns_stream: BEAT_BYTES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  bcnt_q;
    logic [CW-1:0]  dcnt_q;
    logic [CW-1:0]  dnext;
    logic [1:0]     col_q;
    logic [1:0]     mode_q;
    logic [127:0]   st_q;
    logic           ov_q;
    logic           ol_q;
    logic [BW-1:0]  od_q;

    logic           in_fire;
    logic           in_last;
    logic           out_end;
    logic [7:0]     a0, a1, a2, a3;
    logic [7:0]     b0, b1, b2, b3;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m3(input logic [7:0] v);
        return xt(v) ^ v;
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] v);
        return xt(xt(xt(v))) ^ v;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] v);
        return xt(xt(xt(v))) ^ xt(v) ^ v;
    endfunction

    function automatic logic [7:0] md(input logic [7:0] v);
        return xt(xt(xt(v))) ^ xt(xt(v)) ^ v;
    endfunction

    function automatic logic [7:0] me(input logic [7:0] v);
        return xt(xt(xt(v))) ^ xt(xt(v)) ^ xt(v);
    endfunction

    assign in_fire = in_valid && in_ready;
    assign in_last = (bcnt_q == LAST);
    assign out_end = (dcnt_q == LAST);
    assign dnext   = dcnt_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                if (in_fire && in_last) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (col_q == 2'd3) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ov_q && out_ready && out_end) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        in_ready  = (state_q == LOAD);
        busy      = (state_q != LOAD);
        out_valid = ov_q;
        out_data  = od_q;
        out_last  = ol_q;
    end

    // Mix of the column selected by col_q under the latched mode
    always_comb begin
        a0 = st_q[8*int'(col_q) +: 8];
        a1 = st_q[8*(int'(col_q) + 4) +: 8];
        a2 = st_q[8*(int'(col_q) + 8) +: 8];
        a3 = st_q[8*(int'(col_q) + 12) +: 8];
        b0 = a0;
        b1 = a1;
        b2 = a2;
        b3 = a3;
        unique case (mode_q)
            2'b00: begin
                b0 = xt(a0) ^ m3(a1) ^ a2 ^ a3;
                b1 = xt(a1) ^ m3(a2) ^ a3 ^ a0;
                b2 = xt(a2) ^ m3(a3) ^ a0 ^ a1;
                b3 = xt(a3) ^ m3(a0) ^ a1 ^ a2;
            end
            2'b01: begin
                b0 = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
                b1 = me(a1) ^ mb(a2) ^ md(a3) ^ m9(a0);
                b2 = me(a2) ^ mb(a3) ^ md(a0) ^ m9(a1);
                b3 = me(a3) ^ mb(a0) ^ md(a1) ^ m9(a2);
            end
            default: begin
                b0 = a0;
                b1 = a1;
                b2 = a2;
                b3 = a3;
            end
        endcase
    end

    // Datapath: collect beats, mix columns in place, stream through output register
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q <= '0;
            dcnt_q <= '0;
            col_q  <= 2'd0;
            mode_q <= 2'b00;
            st_q   <= '0;
            ov_q   <= 1'b0;
            ol_q   <= 1'b0;
            od_q   <= '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        st_q[int'(bcnt_q)*BW +: BW] <= in_data;
                        if (bcnt_q == '0) begin
                            mode_q <= in_mode;
                        end
                        bcnt_q <= in_last ? '0 : bcnt_q + 1'b1;
                    end
                end
                COMPUTE: begin
                    st_q[8*int'(col_q) +: 8]        <= b0;
                    st_q[8*(int'(col_q) + 4) +: 8]  <= b1;
                    st_q[8*(int'(col_q) + 8) +: 8]  <= b2;
                    st_q[8*(int'(col_q) + 12) +: 8] <= b3;
                    col_q <= col_q + 2'd1;
                end
                DRAIN: begin
                    if (!ov_q) begin
                        ov_q <= 1'b1;
                        od_q <= st_q[int'(dcnt_q)*BW +: BW];
                        ol_q <= out_end;
                    end else if (out_ready) begin
                        if (out_end) begin
                            ov_q   <= 1'b0;
                            ol_q   <= 1'b0;
                            od_q   <= '0;
                            dcnt_q <= '0;
                        end else begin
                            dcnt_q <= dnext;
                            od_q   <= st_q[int'(dnext)*BW +: BW];
                            ol_q   <= (dnext == LAST);
                        end
                    end
                end
                default: begin
                    ov_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_stream.sv
// tb_mix_columns_stream: directed bench for mix_columns_stream.
// Drives a 1-byte and a 4-byte instance with table vectors and corner sequences.
module tb_mix_columns_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv1, ir1, ov1, or1, ol1, bz1;
    logic [7:0]  id1, od1;
    logic [1:0]  im1;
    logic        iv4, ir4, ov4, or4, ol4, bz4;
    logic [31:0] id4, od4;
    logic [1:0]  im4;

    int checks = 0;
    int fails = 0;

    localparam logic [127:0] S_IN  = 128'hd5015c45_d40122_53_d4010a13_d401f2db;
    localparam logic [127:0] S_OUT = 128'hd6019dbc_d70158a1_d501dc4d_d5019f8e;

    mix_columns_stream #(.BEAT_BYTES(1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_mode(im1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .out_last(ol1), .busy(bz1)
    );

    mix_columns_stream #(.BEAT_BYTES(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_mode(im4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .out_last(ol4), .busy(bz4)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic i_rdy(input int bb);
        return (bb == 1) ? ir1 : ir4;
    endfunction

    function automatic logic o_vld(input int bb);
        return (bb == 1) ? ov1 : ov4;
    endfunction

    function automatic logic o_lst(input int bb);
        return (bb == 1) ? ol1 : ol4;
    endfunction

    function automatic logic o_bsy(input int bb);
        return (bb == 1) ? bz1 : bz4;
    endfunction

    function automatic logic [31:0] o_dat(input int bb);
        return (bb == 1) ? {24'h0, od1} : od4;
    endfunction

    task automatic drive_in(input int bb, input logic v,
                            input logic [31:0] d, input logic [1:0] m);
        if (bb == 1) begin
            iv1 = v; id1 = d[7:0]; im1 = m;
        end else begin
            iv4 = v; id4 = d; im4 = m;
        end
    endtask

    task automatic set_ordy(input int bb, input logic r);
        if (bb == 1) or1 = r;
        else or4 = r;
    endtask

    // Feed one state; returns just after the edge that took the last beat.
    task automatic feed(input int bb, input logic [1:0] mode,
                        input logic [127:0] din, input bit flip);
        int nb;
        int g;
        logic [127:0] sh;
        nb = 16 / bb;
        for (int b = 0; b < nb; b++) begin
            sh = din >> (b * 8 * bb);
            drive_in(bb, 1'b1, sh[31:0], (b > 0 && flip) ? 2'b01 : mode);
            g = 0;
            while (!i_rdy(bb) && g < 200) begin
                @(posedge clk); #1; g++;
            end
            if (g >= 200) begin
                checks++; fails++;
                $display("FAIL feed_timeout: in_ready low %0d cycles, need 1", g);
            end
            @(posedge clk); #1;
        end
        drive_in(bb, 1'b0, 32'h0, 2'b00);
    endtask

    // Collect one state; pat 1 toggles out_ready and stalls beat 9 for 7 cycles.
    task automatic drain(input int bb, input int pat,
                         output logic [127:0] dout, output int lat);
        int nb;
        int n;
        int d;
        int stall;
        int cyc;
        bit hold;
        bit rdy;
        logic [32:0] prev;
        nb = 16 / bb;
        n = 0; d = 0; stall = 0; cyc = 0; hold = 0;
        prev = '0;
        dout = '0;
        while (!o_vld(bb) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        lat = n;
        while (d < nb && cyc < 400) begin
            rdy = 1'b1;
            if (pat == 1) begin
                if (d == 9 && stall < 7) begin
                    rdy = 1'b0; stall++;
                end else begin
                    rdy = cyc[0];
                end
            end
            set_ordy(bb, rdy);
            chk("out_valid_held", o_vld(bb), 1);
            if (hold) chk("stall_stable", {o_lst(bb), o_dat(bb)}, prev);
            if (pat == 1) chk("in_ready_low", i_rdy(bb), 0);
            if (rdy) begin
                dout = dout | (128'(o_dat(bb)) << (d * 8 * bb));
                chk("out_last", o_lst(bb), (d == nb - 1));
                d++;
                hold = 0;
            end else begin
                prev = {o_lst(bb), o_dat(bb)};
                hold = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) begin
            checks++; fails++;
            $display("FAIL drain_timeout: %0d beats of %0d", d, nb);
        end
        set_ordy(bb, 1'b0);
        chk("valid_drop", o_vld(bb), 0);
        chk("in_ready_back", i_rdy(bb), 1);
        chk("busy_clear", o_bsy(bb), 0);
    endtask

    typedef struct {
        int           bb;
        logic [1:0]   mode;
        bit           flip;
        int           pat;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [127:0] r1, r2, got;
        int lat;
        int g;
        rst = 1'b1;
        drive_in(1, 1'b0, 32'h0, 2'b00);
        drive_in(4, 1'b0, 32'h0, 2'b00);
        or1 = 1'b0;
        or4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", ir1, 1);
        chk("rst_out_valid", ov1, 0);
        chk("rst_out_last", ol1, 0);
        chk("rst_out_data", od1, 0);
        chk("rst_busy", bz1, 0);
        chk("rst4_in_ready", ir4, 1);
        chk("rst4_out_data", od4, 0);
        rst = 1'b0;

        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        vt[0] = '{1, 2'b00, 1'b0, 0, S_IN, S_OUT};
        vt[1] = '{4, 2'b01, 1'b0, 0, S_OUT, S_IN};
        vt[2] = '{1, 2'b10, 1'b0, 0, r1, r1};
        vt[3] = '{4, 2'b11, 1'b0, 0, r2, r2};
        vt[4] = '{1, 2'b00, 1'b0, 1, S_IN, S_OUT};
        vt[5] = '{1, 2'b00, 1'b1, 0, S_IN, S_OUT};

        for (int i = 0; i < 6; i++) begin
            feed(vt[i].bb, vt[i].mode, vt[i].din, vt[i].flip);
            drain(vt[i].bb, vt[i].pat, got, lat);
            chk($sformatf("vec%0d_data", i), got, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 5);
        end

        // Reset during COMPUTE cycle 2
        feed(1, 2'b00, S_IN, 1'b0);
        chk("compute_busy", bz1, 1);
        chk("compute_in_ready", ir1, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstc_out_valid", ov1, 0);
        chk("rstc_in_ready", ir1, 1);
        chk("rstc_busy", bz1, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("rstc_no_leftover", ov1, 0);
        feed(1, 2'b01, S_OUT, 1'b0);
        drain(1, 0, got, lat);
        chk("rstc_next_data", got, S_IN);
        chk("rstc_next_latency", lat, 5);

        // Reset while DRAIN presents beat 6
        feed(1, 2'b00, S_IN, 1'b0);
        g = 0;
        while (!ov1 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk("rstd_latency", g, 5);
        or1 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        or1 = 1'b0;
        chk("rstd_beat6", od1, S_OUT[55:48]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstd_out_valid", ov1, 0);
        chk("rstd_in_ready", ir1, 1);
        chk("rstd_busy", bz1, 0);
        feed(1, 2'b10, r2, 1'b0);
        drain(1, 0, got, lat);
        chk("rstd_next_data", got, r2);
        chk("rstd_next_latency", lat, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mix_columns_stream.md
Name: mix_columns_stream

Overview:
- Byte-stream AES MixColumns engine with selectable forward, inverse and bypass modes.
- Configurable beat width.
- Collects one 16-byte state, transforms it one column per cycle, then streams the result out.
- Uses valid/ready handshakes on both sides; sits between ShiftRows and AddRoundKey in the round datapath.
- Bypass serves the final round.

Parameters:
BEAT_BYTES, 1, bytes per beat. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
NBEATS, 16/BEAT_BYTES, localparam: beats per state.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  engine accepts an input beat
in_data  input  8*BEAT_BYTES  input bytes
in_mode  input  2  00 forward, 01 inverse, 10 bypass, 11 treated as bypass; sampled on first beat of a state
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts a beat
out_data  output  8*BEAT_BYTES  output bytes
out_last  output  1  marks the final beat of a state
busy  output  1  high in COMPUTE or DRAIN

Behaviour:
- Byte order:
  - State index i = 4*row + col (row-major); column c holds indices c, c+4, c+8, c+12.
  - Within a beat, byte k at bits [8k+7:8k] is state index beat_no*BEAT_BYTES + k.
  - Output uses the same ordering.
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, state=LOAD, beat counters=0, latched mode=00.
- Reset mid-operation: discard the partial state and any pending output; the next clock after rst deassertion behaves as a fresh LOAD.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - Mode is latched on beat 0 and ignored on later beats.
  - On the accept of beat NBEATS-1: in_ready drops the next cycle, go to COMPUTE.
- COMPUTE:
  - Exactly 4 cycles; cycle c transforms column c in place.
  - All modes take 4 cycles, so latency is constant. Bypass copies the column unchanged.
- Forward, column (a0..a3) -> bi = 2·ai ^ 3·a(i+1) ^ a(i+2) ^ a(i+3), indices mod 4.
- Inverse: bi = 0e·ai ^ 0b·a(i+1) ^ 0d·a(i+2) ^ 09·a(i+3).
- GF(2^8) arithmetic:
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0).
  - Higher multipliers are built from xtime chains; all results are 8 bits.
- DRAIN:
  - out_valid=1; out_data presents beat d.
  - Beat d advances only on out_valid && out_ready.
  - out_data and out_last hold stable while stalled.
  - out_last=1 on beat NBEATS-1.
- Latency: last input accept at edge T -> out_valid=1 after edge T+5 (first output beat visible in cycle T+5).
- After the last-beat handshake: out_valid=0 and in_ready=1 from the next cycle (one-cycle turnaround, no input/output overlap).
- in_valid while in_ready=0 is ignored; the source must hold the beat.
- out_ready with out_valid=0 has no effect.
- Counters wrap to 0 at NBEATS; no overflow states exist.
- busy = (state != LOAD).

Test Plan:
- Forward, BEAT_BYTES=1: state with col0=db,13,53,45, col1=f2,0a,22,5c, col2=01,01,01,01, col3=d4,d4,d4,d5 (row-major feed) -> columns 8e,4d,a1,bc / 9f,dc,58,9d / 01,01,01,01 / d5,d5,d7,d6; out_valid rises 5 cycles after the last input accept; out_last on beat 15.
- Inverse, BEAT_BYTES=4: feed the forward outputs above with mode=01 -> original columns restored exactly.
- Bypass, mode=10 and mode=11: random state -> output identical to input; latency still 5 cycles.
- Backpressure, BEAT_BYTES=1: toggle out_ready 0/1 every cycle plus a 7-cycle stall on beat 9 -> no beat lost, duplicated or changed while stalled; in_ready stays 0 until the cycle after the beat-15 handshake.
- Mode latching: change in_mode from 00 to 01 after beat 0 -> forward result produced.
- Reset mid-operation: assert rst in COMPUTE cycle 2, and separately during DRAIN beat 6 -> next cycle out_valid=0, in_ready=1, busy=0; the following state is processed correctly with no leftover bytes.
